// File: rtl/sr_fetch_pkg.sv
// Shared types and constants for the schoolRISCV fetch sequencer.
//   state_t      : fetch FSM states
//   RVOP_*       : opcodes recognised by the static predictor
//   XLEN         : datapath width
//   INSTR_STEP   : sequential PC increment
//   word_align() : clears the byte-offset bits of an address
package sr_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;
   localparam logic [XLEN-1:0] WORD_MASK  = 32'hFFFF_FFFC;

   localparam logic [6:0] RVOP_BRANCH = 7'b1100011;
   localparam logic [6:0] RVOP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP,
      S_HOLD
   } state_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage

// File: rtl/sr_fetch_predict.sv
// Static next-PC predictor for a freshly fetched word.
// Taken for JAL and for backward (negative offset) conditional branches.
// Ports:
//   instr  in  32  fetched instruction word
//   pc     in  32  address the word was fetched from
//   taken  out 1   predicted taken
//   target out 32  predicted target (pc + immJ or pc + immB)
// Purely combinational; only instantiated when SR_FETCH_PREDICT_EN is defined.
module sr_fetch_predict
   import sr_fetch_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   output logic            taken,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_j;
   logic            is_jal;
   logic            is_bwd_branch;

   // Immediate layouts match the decoder's B- and J-type extraction.
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   assign is_jal        = (instr[6:0] == RVOP_JAL);
   assign is_bwd_branch = (instr[6:0] == RVOP_BRANCH) && instr[31];

   assign taken  = is_jal || is_bwd_branch;
   assign target = pc + (is_jal ? imm_j : imm_b);

endmodule

// File: rtl/sr_fetch_ctrl.sv
// Fetch sequencer for schoolRISCV.
// Owns the PC, keeps at most one request outstanding to a variable-latency
// instruction memory, and holds each fetched word for the decoder behind a
// valid/ready handshake. Execute redirects squash a stale fetch or held word.
// Optional feature: define SR_FETCH_PREDICT_EN to follow JAL and backward
// branches speculatively (instr_pred marks such words).
// Ports:
//   clk, rst                         clock, async active-high reset
//   imem_req_vld/rdy, imem_addr      request channel (word address)
//   imem_rsp_vld, imem_rsp_data      response channel, one pulse per request
//   instr_vld/rdy, instr, instr_pc   instruction register to decode
//   instr_pred                       word fetched past a predicted-taken jump
//   redirect_vld, redirect_pc        redirect from execute
module sr_fetch_ctrl
   import sr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_vld,
   input  logic        imem_req_rdy,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_vld,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_vld,
   input  logic        instr_rdy,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_pred,
   input  logic        redirect_vld,
   input  logic [31:0] redirect_pc
);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] redir_pc;
   logic            pred_taken;

   assign imem_addr = pc;
   assign redir_pc  = word_align(redirect_pc);
   assign seq_pc    = pc + INSTR_STEP;

   // Next fetch address after a captured word.
`ifdef SR_FETCH_PREDICT_EN
   logic [XLEN-1:0] pred_target;

   sr_fetch_predict u_predict (
      .instr  (imem_rsp_data),
      .pc     (pc),
      .taken  (pred_taken),
      .target (pred_target)
   );

   assign next_pc = pred_taken ? pred_target : seq_pc;
`else
   assign pred_taken = 1'b0;
   assign next_pc    = seq_pc;
`endif

   // Fetch FSM with PC, request-valid and instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_REQ;
         pc           <= RESET_PC;
         imem_req_vld <= 1'b0;
         instr_vld    <= 1'b0;
         instr        <= '0;
         instr_pc     <= '0;
         instr_pred   <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               // A redirect accepted together with the request leaves a
               // stale response in flight, which S_DROP swallows.
               if (imem_req_vld && imem_req_rdy) begin
                  imem_req_vld <= 1'b0;
                  state        <= redirect_vld ? S_DROP : S_WAIT;
               end else begin
                  imem_req_vld <= 1'b1;
               end
               if (redirect_vld) begin
                  pc <= redir_pc;
               end
            end
            S_WAIT: begin
               if (redirect_vld) begin
                  pc <= redir_pc;
                  if (imem_rsp_vld) begin
                     state        <= S_REQ;
                     imem_req_vld <= 1'b1;
                  end else begin
                     state <= S_DROP;
                  end
               end else if (imem_rsp_vld) begin
                  instr      <= imem_rsp_data;
                  instr_pc   <= pc;
                  instr_vld  <= 1'b1;
                  instr_pred <= pred_taken;
                  pc         <= next_pc;
                  state      <= S_HOLD;
               end
            end
            S_DROP: begin
               if (redirect_vld) begin
                  pc <= redir_pc;
               end
               if (imem_rsp_vld) begin
                  state        <= S_REQ;
                  imem_req_vld <= 1'b1;
               end
            end
            S_HOLD: begin
               // Redirect wins over a same-cycle consume: the word is squashed.
               if (redirect_vld || instr_rdy) begin
                  instr_vld    <= 1'b0;
                  state        <= S_REQ;
                  imem_req_vld <= 1'b1;
               end
               if (redirect_vld) begin
                  pc <= redir_pc;
               end
            end
            default: begin
               state        <= S_REQ;
               imem_req_vld <= 1'b1;
            end
         endcase
      end
   end

   // Responses are only legal while a request is outstanding.
   rsp_protocol_chk : assert property (@(posedge clk) disable iff (rst)
      !(imem_rsp_vld && ((state == S_REQ) || (state == S_HOLD))))
      else $error("imem response received with no request outstanding");

endmodule

// File: tb/tb_sr_fetch_ctrl.sv
// Self-checking bench for sr_fetch_ctrl: directed sequences, a vector table,
// and a randomized run checked against a program-order reference model.
module tb_sr_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        imem_req_vld;
   logic        imem_req_rdy;
   logic [31:0] imem_addr;
   logic        imem_rsp_vld;
   logic [31:0] imem_rsp_data;
   logic        instr_vld;
   logic        instr_rdy;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_pred;
   logic        redirect_vld;
   logic [31:0] redirect_pc;

   sr_fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_vld  (imem_req_vld),
      .imem_req_rdy  (imem_req_rdy),
      .imem_addr     (imem_addr),
      .imem_rsp_vld  (imem_rsp_vld),
      .imem_rsp_data (imem_rsp_data),
      .instr_vld     (instr_vld),
      .instr_rdy     (instr_rdy),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_pred    (instr_pred),
      .redirect_vld  (redirect_vld),
      .redirect_pc   (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // memory model state
   logic        rdy_en;
   logic        rdy_always;
   int          lat_cfg;
   logic        pending;
   int          cnt;
   logic [31:0] acc_addr;
   logic [31:0] acc_q[$];
   logic        ovr_en;
   logic [31:0] ovr_addr;
   logic [31:0] ovr_data;

   // reference model state
   logic [31:0] exp_pc;
   int          consumed;
   logic        hold_prev;
   logic [31:0] h_instr;
   logic [31:0] h_pc;
   logic        req_prev;
   logic [31:0] r_addr;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        pred;
      logic [31:0] next;
   } vec_t;
   vec_t vt[5];

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory contents: unique per address, non-control opcode.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (ovr_en && a == ovr_addr) return ovr_data;
      return {a[26:2] ^ 25'h15A_5A5A, 7'h13};
   endfunction

   // Program-order successor of the word at pc, with offsets built arithmetically.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
      int off;
      off = 4;
`ifdef SR_FETCH_PREDICT_EN
      if (w[6:0] == 7'h6F)
         off = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
               + int'(w[30:21]) * 2;
      else if (w[6:0] == 7'h63 && w[31])
         off = -4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
`endif
      return pc + 32'(off);
   endfunction

   task automatic mem_drive();
      int lat;
      imem_rsp_vld = 1'b0;
      if (pending) begin
         if (cnt == 1) begin
            imem_rsp_vld  = 1'b1;
            imem_rsp_data = memf(acc_addr);
            pending       = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_req_rdy = rdy_en && !pending && (rdy_always || ($urandom_range(0, 1) == 1));
      if (imem_req_vld && imem_req_rdy) begin
         lat      = (lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg;
         pending  = 1'b1;
         cnt      = lat;
         acc_addr = imem_addr;
         acc_q.push_back(imem_addr);
      end
   endtask

   task automatic monitor();
      if (hold_prev) begin
         chk1("hold_vld", instr_vld, 1'b1);
         chk32("hold_instr", instr, h_instr);
         chk32("hold_pc", instr_pc, h_pc);
      end
      if (req_prev) begin
         chk1("req_vld_stable", imem_req_vld, 1'b1);
         chk32("req_addr_stable", imem_addr, r_addr);
      end
      if (redirect_vld) begin
         exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (instr_vld && instr_rdy) begin
         chk32("cons_pc", instr_pc, exp_pc);
         chk32("cons_instr", instr, memf(exp_pc));
         exp_pc = model_next(exp_pc, memf(exp_pc));
         consumed++;
      end
      hold_prev = instr_vld && !instr_rdy && !redirect_vld;
      h_instr   = instr;
      h_pc      = instr_pc;
      req_prev  = imem_req_vld && !imem_req_rdy && !redirect_vld;
      r_addr    = imem_addr;
   endtask

   // One clock: drive memory for the coming edge, check, advance to next negedge.
   task automatic cycle();
      mem_drive();
      monitor();
      @(negedge clk);
   endtask

   task automatic wait_vld(input string nm);
      int n;
      n = 0;
      while (!instr_vld && n < 40) begin
         cycle();
         n++;
      end
      chk1(nm, instr_vld, 1'b1);
   endtask

   task automatic go_idle();
      rdy_en    = 1'b0;
      instr_rdy = 1'b1;
      for (int i = 0; i < 12; i++) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]  pat;
      logic [31:0] held_pc;
      logic        saw_vld;
      int          n;

      vt[0] = '{pc: 32'h0000_0040, data: 32'hFE00_0EE3,
`ifdef SR_FETCH_PREDICT_EN
                pred: 1'b1, next: 32'h0000_003C};
`else
                pred: 1'b0, next: 32'h0000_0044};
`endif
      vt[1] = '{pc: 32'hFFFF_FFFC, data: 32'h0000_0013, pred: 1'b0, next: 32'h0000_0000};
      vt[2] = '{pc: 32'h0000_0200, data: 32'h0100_006F,
`ifdef SR_FETCH_PREDICT_EN
                pred: 1'b1, next: 32'h0000_0210};
`else
                pred: 1'b0, next: 32'h0000_0204};
`endif
      vt[3] = '{pc: 32'h0000_0300, data: 32'h0000_0463, pred: 1'b0, next: 32'h0000_0304};
      vt[4] = '{pc: 32'h0000_1000, data: 32'h1234_5033, pred: 1'b0, next: 32'h0000_1004};

      rst = 1'b1;
      imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rsp_data = '0;
      instr_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
      rdy_en = 1'b0; rdy_always = 1'b1; lat_cfg = 1; pending = 1'b0; cnt = 0;
      acc_addr = '0; ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0;
      exp_pc = 32'h0; consumed = 0; hold_prev = 1'b0; req_prev = 1'b0;
      h_instr = '0; h_pc = '0; r_addr = '0;
      @(negedge clk);
      @(negedge clk);

      // reset values
      chk1("rst_req_vld", imem_req_vld, 1'b0);
      chk32("rst_addr", imem_addr, 32'h0);
      chk1("rst_instr_vld", instr_vld, 1'b0);
      chk32("rst_instr", instr, 32'h0);
      chk32("rst_instr_pc", instr_pc, 32'h0);
      chk1("rst_instr_pred", instr_pred, 1'b0);
      rst = 1'b0;

      // 1: latency 1, decoder always ready -> one word every 3 cycles
      rdy_en = 1'b1; instr_rdy = 1'b1; acc_q.delete();
      pat = '0;
      for (int i = 0; i < 9; i++) begin
         cycle();
         if (i == 0) begin
            chk1("t1_first_req_vld", imem_req_vld, 1'b1);
            chk32("t1_first_addr", imem_addr, 32'h0);
         end
         pat[i] = instr_vld;
      end
      chk32("t1_vld_pattern", {23'd0, pat}, 32'h0000_0124);
      chk32("t1_num_req", 32'(acc_q.size()), 32'd3);
      if (acc_q.size() >= 3) begin
         chk32("t1_addr0", acc_q[0], 32'h0);
         chk32("t1_addr1", acc_q[1], 32'h4);
         chk32("t1_addr2", acc_q[2], 32'h8);
      end

      // 2: stall decode for 5 cycles in hold
      instr_rdy = 1'b0;
      wait_vld("t2_wait_vld");
      held_pc = instr_pc;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk1("t2_no_req", imem_req_vld, 1'b0);
      end
      instr_rdy = 1'b1;
      cycle();
      chk1("t2_req_after", imem_req_vld, 1'b1);
      chk32("t2_addr_after", imem_addr, held_pc + 32'd4);

      // 3: redirect while waiting on a latency-4 response
      lat_cfg = 4;
      cycle();
      redirect_vld = 1'b1; redirect_pc = 32'h0000_0100;
      cycle();
      redirect_vld = 1'b0;
      acc_q.delete();
      saw_vld = 1'b0;
      n = 0;
      while (acc_q.size() == 0 && n < 20) begin
         if (instr_vld) saw_vld = 1'b1;
         cycle();
         n++;
      end
      chk1("t3_stale_dropped", saw_vld, 1'b0);
      chk32("t3_num_req", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() != 0) chk32("t3_req_addr", acc_q[0], 32'h0000_0100);
      lat_cfg = 1;

      // 4: redirect beats consume in hold
      instr_rdy = 1'b0;
      wait_vld("t4_wait_vld");
      redirect_vld = 1'b1; redirect_pc = 32'h0000_2003; instr_rdy = 1'b1;
      cycle();
      redirect_vld = 1'b0;
      chk1("t4_vld_cleared", instr_vld, 1'b0);
      chk1("t4_req_vld", imem_req_vld, 1'b1);
      chk32("t4_req_addr", imem_addr, 32'h0000_2000);
      instr_rdy = 1'b0;
      wait_vld("t4_wait_next");
      chk32("t4_next_pc", instr_pc, 32'h0000_2000);

      // table: one fetch per vector, check captured word and next address
      for (int v = 0; v < 5; v++) begin
         go_idle();
         redirect_vld = 1'b1; redirect_pc = vt[v].pc;
         cycle();
         redirect_vld = 1'b0;
         ovr_en = 1'b1; ovr_addr = vt[v].pc; ovr_data = vt[v].data;
         rdy_en = 1'b1; rdy_always = 1'b1; instr_rdy = 1'b0;
         wait_vld("tv_wait_vld");
         chk32("tv_instr_pc", instr_pc, vt[v].pc);
         chk32("tv_instr", instr, vt[v].data);
         chk1("tv_pred", instr_pred, vt[v].pred);
         rdy_en = 1'b0; instr_rdy = 1'b1;
         cycle();
         chk1("tv_next_req_vld", imem_req_vld, 1'b1);
         chk32("tv_next_addr", imem_addr, vt[v].next);
         ovr_en = 1'b0;
      end

      // randomized run against the reference model
      go_idle();
      rdy_en = 1'b1; rdy_always = 1'b0; lat_cfg = 0;
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         instr_rdy    = ($urandom_range(0, 3) != 0);
         redirect_vld = ($urandom_range(0, 24) == 0);
         redirect_pc  = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
         cycle();
      end
      redirect_vld = 1'b0;
      chk1("rand_progress", consumed > 150, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
